// File: rtl/gpio_pinctrl.sv
// Parametrised GPIO pin controller on the PicoRV32 native bus: pad drive/pull controls,
// synchronised and debounced inputs, set/clear output aliases and a maskable edge/level IRQ.
module gpio_pinctrl #(
  parameter int unsigned GPIO_NUM    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DBNC_WIDTH  = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                mem_valid_i,
  input  logic [7:0]          mem_addr_i,
  input  logic [31:0]         mem_wdata_i,
  input  logic [3:0]          mem_wstrb_i,
  output logic                mem_ready_o,
  output logic [31:0]         mem_rdata_o,
  input  logic [GPIO_NUM-1:0] gpio_in_i,
  output logic [GPIO_NUM-1:0] gpio_out_o,
  output logic [GPIO_NUM-1:0] gpio_oe_o,
  output logic [GPIO_NUM-1:0] gpio_pu_o,
  output logic [GPIO_NUM-1:0] gpio_pd_o,
  output logic                irq_o
);

  typedef logic [GPIO_NUM-1:0]   pins_t;
  typedef logic [DBNC_WIDTH-1:0] cnt_t;

  localparam logic [5:0] AddrOut     = 6'h00;
  localparam logic [5:0] AddrOe      = 6'h01;
  localparam logic [5:0] AddrIn      = 6'h02;
  localparam logic [5:0] AddrPu      = 6'h03;
  localparam logic [5:0] AddrPd      = 6'h04;
  localparam logic [5:0] AddrIrqEn   = 6'h05;
  localparam logic [5:0] AddrIrqType = 6'h06;
  localparam logic [5:0] AddrIrqPol  = 6'h07;
  localparam logic [5:0] AddrIrqStat = 6'h08;
  localparam logic [5:0] AddrDbnc    = 6'h09;
  localparam logic [5:0] AddrOutSet  = 6'h0A;
  localparam logic [5:0] AddrOutClr  = 6'h0B;

  // Zero-extend a pin vector to a bus word.
  function automatic logic [31:0] ext_pins(input pins_t p);
    logic [31:0] w;
    w = '0;
    w[GPIO_NUM-1:0] = p;
    return w;
  endfunction

  // Byte-strobed update of a pin register; bits at or above GPIO_NUM are dropped.
  function automatic pins_t merge_pins(input pins_t cur, input logic [31:0] wd,
                                       input logic [31:0] m);
    logic [31:0] w;
    w = ext_pins(cur);
    w = (w & ~m) | (wd & m);
    return w[GPIO_NUM-1:0];
  endfunction

  // Bus side
  logic        ready_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic [5:0]  word;
  logic        accept;
  logic        wr;
  logic [31:0] bmask;
  pins_t       wd_pins;

  assign word    = mem_addr_i[7:2];
  // A pending acknowledge blocks re-acceptance so a held request is not completed twice.
  assign accept  = mem_valid_i & ~ready_q;
  assign wr      = accept & (|mem_wstrb_i);
  assign bmask   = {{8{mem_wstrb_i[3]}}, {8{mem_wstrb_i[2]}},
                    {8{mem_wstrb_i[1]}}, {8{mem_wstrb_i[0]}}};
  assign wd_pins = merge_pins('0, mem_wdata_i, bmask);

  // Configuration and status registers
  pins_t out_q,  out_d;
  pins_t oe_q,   oe_d;
  pins_t pu_q,   pu_d;
  pins_t pd_q,   pd_d;
  pins_t en_q,   en_d;
  pins_t type_q, type_d;
  pins_t pol_q,  pol_d;
  pins_t stat_q, stat_d;
  cnt_t  dbnc_q, dbnc_d;
  logic  dbnc_wr;

  // Input path
  pins_t sync_q [SYNC_STAGES];
  pins_t sync;
  pins_t samp_q, samp_d;
  pins_t filt_q, filt_d;
  pins_t filt_dly_q;
  cnt_t  cnt_q,  cnt_d;
  logic  tick;
  logic  bypass;
  pins_t stable;
  pins_t evt;
  logic  irq_q;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign bypass = (dbnc_q == '0);
  assign tick   = !bypass && (cnt_q == dbnc_q);
  assign stable = ~(sync ^ samp_q);

  // Edge events compare filt against its one-cycle delay; level events track filt directly.
  assign evt = (type_q & ((pol_q & filt_q & ~filt_dly_q) | (~pol_q & ~filt_q & filt_dly_q)))
             | (~type_q & ~(filt_q ^ pol_q));

  always_comb begin
    cnt_d = cnt_q + cnt_t'(1);
    if (dbnc_wr || bypass || tick) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    samp_d = samp_q;
    filt_d = filt_q;
    if (bypass) begin
      filt_d = sync;
    end else if (tick) begin
      samp_d = sync;
      filt_d = (filt_q & ~stable) | (sync & stable);
    end
  end

  always_comb begin
    out_d   = out_q;
    oe_d    = oe_q;
    pu_d    = pu_q;
    pd_d    = pd_q;
    en_d    = en_q;
    type_d  = type_q;
    pol_d   = pol_q;
    stat_d  = stat_q | evt;
    dbnc_d  = dbnc_q;
    dbnc_wr = 1'b0;
    if (wr) begin
      case (word)
        AddrOut:     out_d  = merge_pins(out_q, mem_wdata_i, bmask);
        AddrOe:      oe_d   = merge_pins(oe_q, mem_wdata_i, bmask);
        AddrPu:      pu_d   = merge_pins(pu_q, mem_wdata_i, bmask);
        AddrPd:      pd_d   = merge_pins(pd_q, mem_wdata_i, bmask);
        AddrIrqEn:   en_d   = merge_pins(en_q, mem_wdata_i, bmask);
        AddrIrqType: type_d = merge_pins(type_q, mem_wdata_i, bmask);
        AddrIrqPol:  pol_d  = merge_pins(pol_q, mem_wdata_i, bmask);
        // New events are OR-ed after the clear so a colliding set survives.
        AddrIrqStat: stat_d = (stat_q & ~wd_pins) | evt;
        AddrDbnc: begin
          dbnc_d  = cnt_t'(((32'(dbnc_q)) & ~bmask) | (mem_wdata_i & bmask));
          dbnc_wr = 1'b1;
        end
        AddrOutSet:  out_d  = out_q | wd_pins;
        AddrOutClr:  out_d  = out_q & ~wd_pins;
        default:     ;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    case (word)
      AddrOut:     rdata_d = ext_pins(out_q);
      AddrOe:      rdata_d = ext_pins(oe_q);
      AddrIn:      rdata_d = ext_pins(filt_q);
      AddrPu:      rdata_d = ext_pins(pu_q);
      AddrPd:      rdata_d = ext_pins(pd_q);
      AddrIrqEn:   rdata_d = ext_pins(en_q);
      AddrIrqType: rdata_d = ext_pins(type_q);
      AddrIrqPol:  rdata_d = ext_pins(pol_q);
      AddrIrqStat: rdata_d = ext_pins(stat_q);
      AddrDbnc:    rdata_d = 32'(dbnc_q);
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= accept;
      if (accept) begin
        rdata_q <= rdata_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q  <= '0;
      oe_q   <= '0;
      pu_q   <= '0;
      pd_q   <= '0;
      en_q   <= '0;
      type_q <= '0;
      pol_q  <= '0;
      stat_q <= '0;
      dbnc_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      oe_q   <= oe_d;
      pu_q   <= pu_d;
      pd_q   <= pd_d;
      en_q   <= en_d;
      type_q <= type_d;
      pol_q  <= pol_d;
      stat_q <= stat_d;
      dbnc_q <= dbnc_d;
      irq_q  <= |(stat_q & en_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      samp_q     <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      cnt_q      <= '0;
    end else begin
      sync_q[0] <= gpio_in_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      samp_q     <= samp_d;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_ready_o = ready_q;
  assign mem_rdata_o = rdata_q;
  assign gpio_out_o  = out_q;
  assign gpio_oe_o   = oe_q;
  assign gpio_pu_o   = pu_q;
  // Pull-up takes priority when both pulls are requested.
  assign gpio_pd_o   = pd_q & ~pu_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_gpio_pinctrl.sv
// Scoreboard bench for gpio_pinctrl: stimulus queues expected read data, a monitor
// pops and compares on every mem_ready_o pulse; pin-level outputs are checked inline.
module tb_gpio_pinctrl;

  localparam int unsigned N = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_valid = 1'b0;
  logic [7:0]    mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_wstrb = '0;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [N-1:0]  gpio_in = '0;
  logic [N-1:0]  gpio_out, gpio_oe, gpio_pu, gpio_pd;
  logic          irq;

  gpio_pinctrl #(.GPIO_NUM(N), .SYNC_STAGES(2), .DBNC_WIDTH(16)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .mem_valid_i (mem_valid),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_wstrb_i (mem_wstrb),
    .mem_ready_o (mem_ready),
    .mem_rdata_o (mem_rdata),
    .gpio_in_i   (gpio_in),
    .gpio_out_o  (gpio_out),
    .gpio_oe_o   (gpio_oe),
    .gpio_pu_o   (gpio_pu),
    .gpio_pd_o   (gpio_pd),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Monitor: every acknowledge must match a queued transaction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && mem_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_ready: got ready=1 expected no pending transfer");
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.chk) check(e.nm, mem_rdata, e.exp);
        end
      end
    end
  end

  task automatic bus(input logic [7:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input logic [31:0] exp, input string nm);
    int n;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    sb.push_back('{ws == 4'h0, exp, nm});
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!mem_ready && n < 4);
    check({nm, "_latency"}, n, 1);
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] wd);
    bus(a, wd, 4'hF, '0, "wr");
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
    bus(a, '0, 4'h0, exp, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out", gpio_out, 0);
    check("rst_oe", gpio_oe, 0);
    check("rst_pupd", {gpio_pu, gpio_pd}, 0);
    check("rst_irq_ready", {irq, mem_ready}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) rd(8'(i * 4), 0, "rst_read");
    // Default config is level/active-low, so idle-low pins latch status (irq stays masked).
    rd(8'h20, 32'h0000_FFFF, "rst_stat_level_low");
    rd(8'h24, 0, "rst_dbnc");
    check("rst_irq_masked", irq, 0);

    // Byte strobes, aliases, width masking, pulls
    bus(8'h00, 32'hFFFF_FFFF, 4'h1, '0, "wr_strb");
    rd(8'h00, 32'h0000_00FF, "out_strb");
    wr(8'h28, 32'h0000_0F00);
    rd(8'h00, 32'h0000_0FFF, "out_set");
    wr(8'h2C, 32'h0000_00F0);
    rd(8'h00, 32'h0000_0F0F, "out_clr");
    check("pin_out", gpio_out, 16'h0F0F);
    rd(8'h28, 0, "out_set_reads0");
    wr(8'h04, 32'hFFFF_FFFF);
    check("pin_oe", gpio_oe, 16'hFFFF);
    rd(8'h04, 32'h0000_FFFF, "oe_width_mask");
    wr(8'h0C, 32'h1);
    wr(8'h10, 32'h1);
    check("pull_conflict", {gpio_pu, gpio_pd}, {16'h0001, 16'h0000});
    wr(8'h10, 32'h3);
    check("pull_pd", gpio_pd, 16'h0002);
    wr(8'h08, 32'hFFFF);
    rd(8'h08, 0, "in_ro");
    rd(8'h30, 0, "unmapped");

    // Rising-edge interrupt, bypass mode
    wr(8'h18, 32'hFFFF);
    wr(8'h1C, 32'hFFFF);
    wr(8'h20, 32'hFFFF);
    rd(8'h20, 0, "stat_cleared");
    wr(8'h14, 32'h1);
    @(negedge clk);
    gpio_in[0] = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!irq && n < 10);
    check("irq_rise_latency", n, 5);
    rd(8'h08, 32'h1, "in_pin0");
    rd(8'h20, 32'h1, "stat_pin0");
    wr(8'h20, 32'h1);
    check("irq_before_clear_lag", irq, 1);
    @(posedge clk);
    #1;
    check("irq_after_clear", irq, 0);
    @(negedge clk);
    gpio_in[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("irq_fall_edge", irq, 0);
    rd(8'h20, 0, "stat_fall_edge");

    // Debounce, tick every 5 cycles
    wr(8'h24, 32'h4);
    rd(8'h24, 32'h4, "dbnc_cfg");
    @(negedge clk);
    gpio_in[3] = 1'b1;
    repeat (3) @(negedge clk);
    gpio_in[3] = 1'b0;
    repeat (12) @(negedge clk);
    rd(8'h08, 0, "dbnc_glitch");
    @(negedge clk);
    gpio_in[3] = 1'b1;
    repeat (12) @(negedge clk);
    rd(8'h08, 32'h8, "dbnc_accept");
    @(negedge clk);
    gpio_in[3] = 1'b0;
    repeat (14) @(negedge clk);
    rd(8'h08, 0, "dbnc_release");
    wr(8'h24, 32'h0);

    // Level-high interrupt on pin 5; W1C collides with the still-active level
    wr(8'h20, 32'hFFFF);
    wr(8'h18, 32'hFFDF);
    wr(8'h14, 32'h20);
    check("lvl_irq_idle", irq, 0);
    @(negedge clk);
    gpio_in[5] = 1'b1;
    repeat (6) @(negedge clk);
    check("lvl_irq_set", irq, 1);
    wr(8'h20, 32'h20);
    check("lvl_irq_hold0", irq, 1);
    @(posedge clk);
    #1;
    check("lvl_irq_hold1", irq, 1);
    rd(8'h20, 32'h20, "lvl_stat_reset");
    @(negedge clk);
    gpio_in[5] = 1'b0;
    repeat (5) @(negedge clk);
    wr(8'h20, 32'h20);
    rd(8'h20, 0, "lvl_stat_clear");
    check("lvl_irq_drop", irq, 0);
    wr(8'h18, 32'hFFFF);

    // Edge event on pin 6 lands on the same edge as its W1C
    @(negedge clk);
    gpio_in[6] = 1'b1;
    repeat (2) @(negedge clk);
    wr(8'h20, 32'h40);
    rd(8'h20, 32'h40, "w1c_collision");
    wr(8'h20, 32'h40);
    rd(8'h20, 0, "w1c_plain");
    @(negedge clk);
    gpio_in[6] = 1'b0;
    repeat (5) @(negedge clk);

    // Held request: one acknowledge only
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 8'h00;
    mem_wstrb = 4'h0;
    sb.push_back('{1'b1, 32'h0000_0F0F, "hold_read"});
    @(posedge clk);
    #1;
    check("hold_ack1", mem_ready, 1);
    @(posedge clk);
    #1;
    check("hold_no_double", mem_ready, 0);
    @(negedge clk);
    mem_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while a write is being acknowledged
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 8'h0C;
    mem_wdata = 32'hFFFF;
    mem_wstrb = 4'hF;
    sb.push_back('{1'b0, '0, "rst_mid"});
    @(posedge clk);
    #1;
    check("mid_ready", mem_ready, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_ready_drop", mem_ready, 0);
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = '0;
    repeat (2) @(negedge clk);
    check("mid_pins", {gpio_out, gpio_pu}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_irq", irq, 0);
    rd(8'h0C, 0, "post_rst_pu");
    wr(8'h18, 32'hFFFF);
    wr(8'h20, 32'hFFFF);
    repeat (4) @(negedge clk);
    rd(8'h20, 0, "post_rst_no_edge");

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
